peaton_button_conditioner: RTL and testbench
============================================

// Module: peaton_button_conditioner
// PURPOSE
// - Conditions the raw pedestrian push-button before it reaches the traffic-light controller's b_npeaton input.
// - Synchronises the async button into clk, debounces it with a 4-state FSM and drives a clean active-low level.
// - Also emits single-cycle press/release pulses and a saturating press counter for status LEDs/7-seg.
// PARAMETERS
// - FPGAFREQ       50_000_000  clock frequency in Hz
// - T_DEBOUNCE_MS  20          debounce window in ms; DB_CYCLES = (FPGAFREQ/1000)*T_DEBOUNCE_MS, must be >= 2
// - T_HOLD_MS      1000        long-press threshold in ms; HOLD_CYCLES = (FPGAFREQ/1000)*T_HOLD_MS (BTN_HOLD_EN only)
// - SYNC_STAGES    2           synchroniser flip-flops, >= 2
// PORTS
// - clk            in   1  system clock
// - nreset         in   1  asynchronous, active-low reset
// - b_npeaton_raw  in   1  raw button, active-low (0 = pressed), asynchronous to clk
// - b_npeaton      out  1  debounced level, active-low; connects directly to the traffic-light b_npeaton
// - press_pulse    out  1  one-cycle high on each accepted press
// - release_pulse  out  1  one-cycle high on each accepted release
// - press_count    out  8  accepted presses since reset, saturates at 255
// - hold_pulse     out  1  one-cycle high on long press (constant 0 without BTN_HOLD_EN)
// BEHAVIOUR
// - Reset (async, nreset=0): sync FFs=1, state=S_IDLE, counters=0, b_npeaton=1, all pulses=0, press_count=0.
// - Synchroniser: SYNC_STAGES FFs, reset to 1. The FSM sees only the last stage (sync_n).
// - Debounce counter: width $clog2(max(DB_CYCLES,HOLD_CYCLES)+1). It clears on every state change.
// - FSM states and transitions:
//   S_IDLE:     b_npeaton=1. sync_n=0 -> S_PRESS_CHK.
//   S_PRESS_CHK: count up. sync_n=1 before reaching DB_CYCLES-1 -> S_IDLE with no pulse (glitch rejected).
//                count==DB_CYCLES-1 with sync_n=0 -> S_PRESSED.
//   S_PRESSED:  b_npeaton=0. press_pulse=1 only in the first cycle of the state. sync_n=1 -> S_REL_CHK.
//   S_REL_CHK:  b_npeaton stays 0. count up. sync_n=0 before DB_CYCLES-1 -> S_PRESSED with no new press_pulse (bounce).
//               count==DB_CYCLES-1 with sync_n=1 -> S_IDLE, release_pulse=1 for that cycle.
// - Latency: a clean raw press is sampled low at edge k. press_pulse and b_npeaton=0 are valid after edge k+SYNC_STAGES+DB_CYCLES.
//   Release latency is identical and is measured to release_pulse / b_npeaton=1.
// - press_count increments in the same cycle as press_pulse and holds at 255 (no wrap).
// - Pulses are registered outputs, never high two cycles in a row, and press_pulse and release_pulse are never high together.
// - Reset mid-press: the block returns to S_IDLE at once. A button still held after reset release is accepted as a new press after the full debounce.
// - A raw glitch shorter than DB_CYCLES never changes b_npeaton.
// CONFIGURATION
// - Macro BTN_HOLD_EN defined: a hold counter runs while in S_PRESSED or S_REL_CHK.
//   When it reaches HOLD_CYCLES-1 (measured from S_PRESSED entry), hold_pulse=1 for one cycle, at most once per accepted press.
//   The hold counter resets on S_IDLE and freezes after firing.
// - BTN_HOLD_EN undefined: no hold counter or logic; hold_pulse tied to 0. All other behaviour is identical.
// TESTING (bench: FPGAFREQ=8000, T_DEBOUNCE_MS=2 -> DB_CYCLES=16, T_HOLD_MS=4 -> HOLD_CYCLES=32, SYNC_STAGES=2)
// - Reset asserted mid-run -> b_npeaton=1, press_count=0, all pulses 0 immediately, with no clk edge needed.
// - Raw low for 100 cycles, then high -> one press_pulse 18 edges after the first low sample, count=1.
//   After release: one release_pulse 18 edges later, b_npeaton back to 1.
// - Raw low for 10 cycles only -> no pulse, b_npeaton stays 1, count stays 0.
// - Press held, then a 5-cycle high bounce, then low again -> b_npeaton stays 0, no extra press_pulse or release_pulse.
// - 260 clean presses -> press_count reads 255, and the 256th-260th press_pulses still fire.
// - BTN_HOLD_EN defined, press held 100 cycles -> exactly one hold_pulse, 31 edges after press_pulse.
//   Same stimulus with BTN_HOLD_EN undefined -> hold_pulse always 0.

Source files
------------

// File: rtl/peaton_button_conditioner.sv
// peaton_button_conditioner
// Conditions the raw active-low pedestrian button for the traffic-light
// controller. It synchronises the button, debounces it, and produces a clean
// active-low level, press and release pulses, and a saturating press counter.
// Optional long-press detection is enabled by defining the macro BTN_HOLD_EN.
module peaton_button_conditioner #(
    parameter int FPGAFREQ      = 50_000_000,
    parameter int T_DEBOUNCE_MS = 20,
    parameter int T_HOLD_MS     = 1000,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       b_npeaton_raw,
    output logic       b_npeaton,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic [7:0] press_count,
    output logic       hold_pulse
);

    localparam int DB_CYCLES   = (FPGAFREQ / 1000) * T_DEBOUNCE_MS;
    localparam int HOLD_CYCLES = (FPGAFREQ / 1000) * T_HOLD_MS;
    localparam int MAX_CYCLES  = (DB_CYCLES > HOLD_CYCLES) ? DB_CYCLES : HOLD_CYCLES;
    localparam int CW          = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS_CHK,
        S_PRESSED,
        S_REL_CHK
    } state_t;

    state_t                 state;
    logic [CW-1:0]          db_cnt;
    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync_n;

    // Synchroniser chain for the asynchronous button; idles high (released).
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync_ff <= '1;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], b_npeaton_raw};
        end
    end

    assign sync_n = sync_ff[SYNC_STAGES-1];

    // Debounce FSM with registered level, pulses and saturating press counter.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state         <= S_IDLE;
            db_cnt        <= '0;
            b_npeaton     <= 1'b1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            press_count   <= '0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    b_npeaton <= 1'b1;
                    if (!sync_n) begin
                        state  <= S_PRESS_CHK;
                        db_cnt <= '0;
                    end
                end
                S_PRESS_CHK: begin
                    if (sync_n) begin
                        state  <= S_IDLE;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        state       <= S_PRESSED;
                        db_cnt      <= '0;
                        b_npeaton   <= 1'b0;
                        press_pulse <= 1'b1;
                        if (press_count != 8'hFF) begin
                            press_count <= press_count + 8'd1;
                        end
                    end else begin
                        db_cnt <= db_cnt + CNT_ONE;
                    end
                end
                S_PRESSED: begin
                    b_npeaton <= 1'b0;
                    if (sync_n) begin
                        state  <= S_REL_CHK;
                        db_cnt <= '0;
                    end
                end
                S_REL_CHK: begin
                    if (!sync_n) begin
                        state  <= S_PRESSED;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        state         <= S_IDLE;
                        db_cnt        <= '0;
                        b_npeaton     <= 1'b1;
                        release_pulse <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + CNT_ONE;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    db_cnt <= '0;
                end
            endcase
        end
    end

`ifdef BTN_HOLD_EN
    localparam logic [CW-1:0] HOLD_FIRE = CW'(HOLD_CYCLES - 2);

    logic [CW-1:0] hold_cnt;
    logic          hold_done;

    // Long-press timer, measured from press acceptance; fires once per press.
    // The pulse is launched when the count moves to HOLD_CYCLES-1, so the
    // registered output appears in the same cycle the count reaches it.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            hold_cnt   <= '0;
            hold_done  <= 1'b0;
            hold_pulse <= 1'b0;
        end else begin
            hold_pulse <= 1'b0;
            if (state == S_PRESSED || state == S_REL_CHK) begin
                if (!hold_done) begin
                    hold_cnt <= hold_cnt + CNT_ONE;
                    if (hold_cnt == HOLD_FIRE) begin
                        hold_pulse <= 1'b1;
                        hold_done  <= 1'b1;
                    end
                end
            end else begin
                hold_cnt  <= '0;
                hold_done <= 1'b0;
            end
        end
    end
`else
    assign hold_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_peaton_button_conditioner.sv
// Self-checking bench for peaton_button_conditioner (16-cycle debounce,
// 32-cycle hold, 2 sync stages). Every cycle is compared against a run-length
// model of the debounce rules; table vectors and directed sequences add
// end-of-scenario checks.
module tb_peaton_button_conditioner;

    localparam int S    = 2;
    localparam int DB   = 16;
    localparam int HOLD = 32;
`ifdef BTN_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic       raw = 1'b1;
    logic       b_npeaton, press_pulse, release_pulse, hold_pulse;
    logic [7:0] press_count;

    peaton_button_conditioner #(
        .FPGAFREQ(8000),
        .T_DEBOUNCE_MS(2),
        .T_HOLD_MS(4),
        .SYNC_STAGES(S)
    ) dut (
        .clk(clk),
        .nreset(nreset),
        .b_npeaton_raw(raw),
        .b_npeaton(b_npeaton),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .press_count(press_count),
        .hold_pulse(hold_pulse)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int obs_press, obs_rel, obs_hold;
    int last_press_cyc, last_hold_cyc;

    // Reference model: the button as seen after S cycles of delay; the level
    // flips once DB+1 consecutive samples disagree with it.
    logic m_q[$];
    logic m_level;
    int   m_run, m_age, m_cnt;
    logic m_pp, m_rp, m_hp;

    task automatic model_reset();
        m_q = {};
        for (int i = 0; i < S; i++) m_q.push_back(1'b1);
        m_level = 1'b1;
        m_run = 0;
        m_age = 0;
        m_cnt = 0;
        m_pp = 1'b0;
        m_rp = 1'b0;
        m_hp = 1'b0;
    endtask

    task automatic model_edge(input logic v);
        logic in;
        in = m_q.pop_front();
        m_q.push_back(v);
        m_pp = 1'b0;
        m_rp = 1'b0;
        m_hp = 1'b0;
        if (!m_level) begin
            m_age++;
            if (m_age == HOLD - 1) m_hp = HOLD_EN;
        end
        if (in != m_level) begin
            m_run++;
            if (m_run == DB + 1) begin
                m_level = in;
                m_run = 0;
                if (!in) begin
                    m_pp = 1'b1;
                    m_age = 0;
                    if (m_cnt < 255) m_cnt++;
                end else begin
                    m_rp = 1'b1;
                end
            end
        end else begin
            m_run = 0;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic int outs();
        return int'({b_npeaton, press_pulse, release_pulse, hold_pulse, press_count});
    endfunction

    // One clock: drive at negedge, update model at posedge, compare 1ns later.
    task automatic step(input logic v);
        @(negedge clk);
        raw = v;
        @(posedge clk);
        if (!nreset) model_reset();
        else model_edge(v);
        #1;
        cyc++;
        if (press_pulse) begin obs_press++; last_press_cyc = cyc; end
        if (release_pulse) obs_rel++;
        if (hold_pulse) begin obs_hold++; last_hold_cyc = cyc; end
        check("cycle_outputs", outs(),
              int'({m_level, m_pp, m_rp, m_hp, 8'(m_cnt)}));
    endtask

    task automatic clear_obs();
        obs_press = 0;
        obs_rel = 0;
        obs_hold = 0;
        last_press_cyc = 0;
        last_hold_cyc = 0;
    endtask

    // Synchronous-looking reset sequence; release lands mid-cycle.
    task automatic reset_dut();
        nreset = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1);
        #2;
        nreset = 1'b1;
        clear_obs();
    endtask

    typedef struct {
        int low;
        int high;
        int exp_press;
        int exp_rel;
    } vec_t;
    vec_t tbl[6];

    initial begin
        int lat;
        bit b_rose;
        logic v;
        int len;

        model_reset();
        clear_obs();

        tbl[0] = '{low: 100, high: 40, exp_press: 1, exp_rel: 1};
        tbl[1] = '{low: 10,  high: 40, exp_press: 0, exp_rel: 0};
        tbl[2] = '{low: 16,  high: 40, exp_press: 0, exp_rel: 0};
        tbl[3] = '{low: 17,  high: 40, exp_press: 1, exp_rel: 1};
        tbl[4] = '{low: 1,   high: 30, exp_press: 0, exp_rel: 0};
        tbl[5] = '{low: 40,  high: 10, exp_press: 1, exp_rel: 0};

        // Reset state
        reset_dut();
        check("reset_state", outs(), int'({1'b1, 1'b0, 1'b0, 1'b0, 8'd0}));

        // Table-driven press/release vectors, each from reset
        for (int i = 0; i < 6; i++) begin
            reset_dut();
            for (int j = 0; j < tbl[i].low; j++) step(1'b0);
            for (int j = 0; j < tbl[i].high; j++) step(1'b1);
            check("tbl_press_pulses", obs_press, tbl[i].exp_press);
            check("tbl_release_pulses", obs_rel, tbl[i].exp_rel);
            check("tbl_count", int'(press_count), tbl[i].exp_press);
            check("tbl_level", int'(b_npeaton), (tbl[i].exp_press != tbl[i].exp_rel) ? 0 : 1);
        end

        // Press latency: first low sample is edge 0
        reset_dut();
        lat = -1;
        step(1'b0);
        for (int n = 1; n <= 40; n++) begin
            step(1'b0);
            if (press_pulse) begin lat = n; break; end
        end
        check("press_latency", lat, 18);
        check("press_level", int'(b_npeaton), 0);
        for (int n = 0; n < 60; n++) step(1'b0);
        lat = -1;
        step(1'b1);
        for (int n = 1; n <= 40; n++) begin
            step(1'b1);
            if (release_pulse) begin lat = n; break; end
        end
        check("release_latency", lat, 18);
        check("release_level", int'(b_npeaton), 1);
        check("latency_count", int'(press_count), 1);

        // Bounce while held: no release, no extra press
        reset_dut();
        for (int n = 0; n < 40; n++) step(1'b0);
        clear_obs();
        b_rose = 1'b0;
        for (int n = 0; n < 5; n++) begin step(1'b1); if (b_npeaton) b_rose = 1'b1; end
        for (int n = 0; n < 30; n++) begin step(1'b0); if (b_npeaton) b_rose = 1'b1; end
        check("bounce_level_rose", int'(b_rose), 0);
        check("bounce_press", obs_press, 0);
        check("bounce_release", obs_rel, 0);
        for (int n = 0; n < 30; n++) step(1'b1);

        // Saturation: 260 clean presses
        reset_dut();
        for (int p = 0; p < 260; p++) begin
            for (int n = 0; n < 20; n++) step(1'b0);
            for (int n = 0; n < 20; n++) step(1'b1);
            if (p == 254) check("count_at_255", int'(press_count), 255);
        end
        check("sat_count", int'(press_count), 255);
        check("sat_press_pulses", obs_press, 260);
        check("sat_release_pulses", obs_rel, 260);

        // Long press
        reset_dut();
        for (int n = 0; n < 100; n++) step(1'b0);
        check("hold_pulses", obs_hold, HOLD_EN ? 1 : 0);
`ifdef BTN_HOLD_EN
        check("hold_distance", last_hold_cyc - last_press_cyc, 31);
`endif
        for (int n = 0; n < 40; n++) step(1'b1);

        // Async reset mid-press, button still held afterwards
        reset_dut();
        for (int n = 0; n < 30; n++) step(1'b0);
        check("pre_reset_count", int'(press_count), 1);
        #2;
        nreset = 1'b0;
        #1;
        check("async_reset", outs(), int'({1'b1, 1'b0, 1'b0, 1'b0, 8'd0}));
        for (int n = 0; n < 3; n++) step(1'b0);
        #2;
        nreset = 1'b1;
        clear_obs();
        lat = -1;
        step(1'b0);
        for (int n = 1; n <= 40; n++) begin
            step(1'b0);
            if (press_pulse) begin lat = n; break; end
        end
        check("post_reset_press_latency", lat, 18);
        check("post_reset_count", int'(press_count), 1);
        for (int n = 0; n < 40; n++) step(1'b1);

        // Randomised run lengths against the model
        reset_dut();
        v = 1'b1;
        while (cyc < 20000) begin
            v = ~v;
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(18, 60))
                                              : int'($urandom_range(1, 20));
            for (int n = 0; n < len; n++) step(v);
        end
        for (int n = 0; n < 40; n++) step(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
